// File: rtl/collatz_orbit_gen_pkg.sv
// Shared types for the Collatz orbit engine family.
// Holds the completion status codes and the FSM state encoding.
package collatz_orbit_gen_pkg;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ZERO = 2'd1,
    ST_OVF  = 2'd2,
    ST_TMO  = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/collatz_orbit_gen_if.sv
// Orbit value stream from the engine to the display/logging consumer.
// A beat transfers on a rising clk when x_vld && x_rdy; while x_vld is high and
// x_rdy is low the producer holds x stable, and x_vld never drops before transfer.
interface collatz_orbit_gen_if #(parameter int KW = 20);
  logic [KW-1:0] x;
  logic          x_vld;
  logic          x_rdy;

  modport master (output x, output x_vld, input x_rdy);
  modport slave  (input x, input x_vld, output x_rdy);
endinterface

// File: rtl/collatz_orbit_gen_step.sv
// One Collatz transition, combinational. Works in KW+2 bits so the overflow
// flag is simply "any bit above KW-1 is set" in the full-precision result.
module collatz_orbit_gen_step #(
  parameter int KW = 20
) (
  input  logic [KW-1:0] k,
  input  logic          mode,
  output logic [KW-1:0] nxt,
  output logic          ovf
);

  logic [KW+1:0] tri_v;
  logic [KW+1:0] wide;

  always_comb begin
    tri_v = {2'b00, k} + {1'b0, k, 1'b0} + {{(KW+1){1'b0}}, 1'b1};
    if (!k[0]) begin
      wide = {2'b00, k} >> 1;
    end else if (mode) begin
      wide = tri_v >> 1;
    end else begin
      wide = tri_v;
    end
    nxt = wide[KW-1:0];
    ovf = |wide[KW+1:KW];
  end

endmodule

// File: rtl/collatz_orbit_gen.sv
// Collatz orbit engine: takes a seed on start, streams every orbit value, and
// reports transitions taken, the largest emitted value and why the orbit ended.
module collatz_orbit_gen
  import collatz_orbit_gen_pkg::*;
#(
  parameter int W        = 16,
  parameter int KW       = 20,
  parameter int SW       = 16,
  parameter int STEP_MAX = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         co,
  input  logic                 st,
  input  logic                 mode,
  collatz_orbit_gen_if.master  xs,
  output logic                 bs,
  output logic                 done,
  output logic [SW-1:0]        steps,
  output logic [KW-1:0]        peak,
  output logic [1:0]           status,
  output state_t               fsm_state
);

  localparam logic [SW-1:0] STEP_LIM = SW'(STEP_MAX);
  localparam logic [KW-1:0] K_ONE    = {{(KW-1){1'b0}}, 1'b1};

  state_t        state;
  status_t       status_q;
  logic [KW-1:0] k;
  logic [KW-1:0] nxt;
  logic          mode_q;
  logic          ovf;
  logic          x_vld_q;

  collatz_orbit_gen_step #(.KW(KW)) u_step (
    .k    (k),
    .mode (mode_q),
    .nxt  (nxt),
    .ovf  (ovf)
  );

  assign xs.x      = k;
  assign xs.x_vld  = x_vld_q;
  assign status    = status_q;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      status_q <= ST_OK;
      k        <= '0;
      mode_q   <= 1'b0;
      x_vld_q  <= 1'b0;
      bs       <= 1'b0;
      done     <= 1'b0;
      steps    <= '0;
      peak     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st) begin
            steps <= '0;
            peak  <= '0;
            bs    <= 1'b1;
            if (co != '0) begin
              k       <= {{(KW-W){1'b0}}, co};
              mode_q  <= mode;
              x_vld_q <= 1'b1;
              state   <= S_RUN;
            end else begin
              status_q <= ST_ZERO;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_RUN: begin
          // Nothing moves while the consumer stalls, so no beat is lost or repeated.
          if (xs.x_rdy) begin
            peak <= (k > peak) ? k : peak;
            if (k == K_ONE) begin
              status_q <= ST_OK;
              x_vld_q  <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else if (steps == STEP_LIM) begin
              status_q <= ST_TMO;
              x_vld_q  <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else if (ovf) begin
              status_q <= ST_OVF;
              x_vld_q  <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              k     <= nxt;
              steps <= steps + SW'(1);
            end
          end
        end
        S_DONE: begin
          bs    <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
